// File: rtl/doodle_pkg.sv
// Shared constants, platform slot layout and collider FSM states for the doodle game.
package doodle_pkg;
  localparam int N_PLATFORMS = 93;
  localparam int PLAT_W      = 100;
  localparam int PLAT_H      = 30;
  localparam int SCROLL_STEP = 12;

  // [0] = top y, [1] = left x
  typedef logic signed [1:0][10:0] platform_t;

  typedef enum logic [1:0] {IDLE, SCAN, DONE} collider_state_t;
endpackage

// File: rtl/platform_hit_test.sv
// Combinational landing test of the doodle's feet against one platform slot.
// 12-bit signed compares; all operands sign-extended before use.
module platform_hit_test
  import doodle_pkg::*;
#(
  parameter int DOODLE_W = 80,
  parameter int DOODLE_H = 80,
  parameter int LAND_TOL = SCROLL_STEP
) (
  input  logic [10:0] i_px,
  input  logic [10:0] i_py,
  input  logic        i_active,
  input  logic [10:0] i_dx,
  input  logic [9:0]  i_dy,
  input  logic        i_falling,
  output logic        o_hit
);
  localparam logic signed [11:0] C_RIGHT = 12'(DOODLE_W - 1);
  localparam logic signed [11:0] C_FEET  = 12'(DOODLE_H);
  localparam logic signed [11:0] C_PLAT  = 12'(PLAT_W - 1);
  localparam logic signed [11:0] C_TOL   = 12'(LAND_TOL - 1);

  logic signed [11:0] w_px;
  logic signed [11:0] w_py;
  logic signed [11:0] w_dx;
  logic signed [11:0] w_dy;
  logic signed [11:0] w_feet;

  assign w_px   = {i_px[10], i_px};
  assign w_py   = {i_py[10], i_py};
  assign w_dx   = {i_dx[10], i_dx};
  assign w_dy   = {{2{i_dy[9]}}, i_dy};
  assign w_feet = w_dy + C_FEET;

  assign o_hit = i_active && i_falling
              && (w_dx + C_RIGHT >= w_px)
              && (w_dx <= w_px + C_PLAT)
              && (w_feet >= w_py)
              && (w_feet <= w_py + C_TOL);
endmodule

// File: rtl/platform_collider.sv
// Per-frame serial landing scan over all platform slots; results commit in DONE with a scan_done pulse.
// Optional PLATFORM_COLLIDER_HOLDOFF_EN masks move_collision for 15 scans after a reported landing.
module platform_collider
  import doodle_pkg::*;
#(
  parameter int FPS      = 60,
  parameter int CLK      = 50_000_000,
  parameter int N_PLAT   = N_PLATFORMS,
  parameter int DOODLE_W = 80,
  parameter int DOODLE_H = 80,
  parameter int LAND_TOL = SCROLL_STEP,
  localparam int FW      = $clog2(CLK / FPS) + 1
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [FW-1:0]                        fps_counter,
  input  logic [10:0]                          doodle_x,
  input  logic [9:0]                           doodle_y,
  input  logic                                 doodle_falling,
  input  logic signed [N_PLAT-1:0][1:0][10:0]  platforms,
  input  logic [N_PLAT-1:0]                    platform_activation,
  output logic                                 move_collision,
  output logic [6:0]                           hit_index,
  output logic signed [10:0]                   hit_y,
  output logic                                 scan_busy,
  output logic                                 scan_done
);
  if ((N_PLAT + 2 >= CLK / FPS) || (N_PLAT > 128)) begin : g_cfg_check
    $error("platform_collider: scan does not fit in one frame or slot index exceeds 7 bits");
  end

  collider_state_t    r_state;
  collider_state_t    w_next;
  logic [6:0]         r_idx;
  logic [10:0]        r_dx;
  logic [9:0]         r_dy;
  logic               r_fall;
  logic               r_found;
  logic [6:0]         r_hit_idx;
  logic signed [10:0] r_hit_y;
  logic               w_tick;
  logic               w_hit;
  platform_t          w_slot;
`ifdef PLATFORM_COLLIDER_HOLDOFF_EN
  logic [3:0]         r_holdoff;
`endif

  assign w_tick = &fps_counter;
  assign w_slot = platforms[r_idx];

  platform_hit_test #(
    .DOODLE_W (DOODLE_W),
    .DOODLE_H (DOODLE_H),
    .LAND_TOL (LAND_TOL)
  ) u_hit (
    .i_px      (w_slot[1]),
    .i_py      (w_slot[0]),
    .i_active  (platform_activation[r_idx]),
    .i_dx      (r_dx),
    .i_dy      (r_dy),
    .i_falling (r_fall),
    .o_hit     (w_hit)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    scan_busy = 1'b0;
    case (r_state)
      IDLE: if (w_tick) w_next = SCAN;
      SCAN: begin
        scan_busy = 1'b1;
        if (r_idx == 7'(N_PLAT - 1)) w_next = DONE;
      end
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_idx          <= '0;
      r_dx           <= '0;
      r_dy           <= '0;
      r_fall         <= 1'b0;
      r_found        <= 1'b0;
      r_hit_idx      <= '0;
      r_hit_y        <= '0;
      move_collision <= 1'b0;
      hit_index      <= '0;
      hit_y          <= '0;
      scan_done      <= 1'b0;
`ifdef PLATFORM_COLLIDER_HOLDOFF_EN
      r_holdoff      <= '0;
`endif
    end else begin
      scan_done <= 1'b0;
      case (r_state)
        IDLE: if (w_tick) begin
          // Doodle is frozen for the scan; platforms stay live to see post-scroll positions.
          r_idx   <= '0;
          r_dx    <= doodle_x;
          r_dy    <= doodle_y;
          r_fall  <= doodle_falling;
          r_found <= 1'b0;
        end
        SCAN: begin
          if (w_hit && !r_found) begin
            r_found   <= 1'b1;
            r_hit_idx <= r_idx;
            r_hit_y   <= w_slot[0];
          end
          r_idx <= r_idx + 7'd1;
        end
        DONE: begin
          scan_done <= 1'b1;
`ifdef PLATFORM_COLLIDER_HOLDOFF_EN
          if (r_holdoff != 4'd0) begin
            move_collision <= 1'b0;
            r_holdoff      <= r_holdoff - 4'd1;
          end else begin
            move_collision <= r_found;
            if (r_found) r_holdoff <= 4'd15;
          end
`else
          move_collision <= r_found;
`endif
          if (r_found) begin
            hit_index <= r_hit_idx;
            hit_y     <= r_hit_y;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_platform_collider.sv
// Scoreboard bench for platform_collider: a driver predicts each scan's committed result from the
// landing rules, a monitor pops and compares on every scan_done and checks hold/busy timing.
module tb_platform_collider;
  localparam int NP = 93;
  localparam int FW = 21;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [FW-1:0] fps = '0;
  logic [10:0] dx = '0;
  logic [9:0]  dy = '0;
  logic fall = 1'b0;
  logic signed [NP-1:0][1:0][10:0] plats = '0;
  logic [NP-1:0] act = '0;
  logic mc;
  logic [6:0] hidx;
  logic signed [10:0] hy;
  logic busy;
  logic done;

  platform_collider dut (
    .clk(clk), .rst(rst), .fps_counter(fps), .doodle_x(dx), .doodle_y(dy),
    .doodle_falling(fall), .platforms(plats), .platform_activation(act),
    .move_collision(mc), .hit_index(hidx), .hit_y(hy), .scan_busy(busy), .scan_done(done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    logic              mc;
    logic [6:0]        idx;
    logic signed [10:0] y;
    int                cyc;
  } exp_t;

  exp_t q[$];
  int errors = 0;
  int checks = 0;
  int busy_cnt = 0;

  // Currently reported outputs (monitor view) and predicted committed state (driver view).
  logic cur_mc = 1'b0;
  logic [6:0] cur_idx = '0;
  logic signed [10:0] cur_y = '0;
  logic m_mc = 1'b0;
  logic [6:0] m_idx = '0;
  logic signed [10:0] m_y = '0;
  int m_hold = 0;

  task automatic check(input string name, input logic signed [31:0] got, input logic signed [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, got, want, cyc);
    end
  endtask

  // Reference: first active slot whose box overlaps horizontally and whose top lies within
  // the 12-px window at or just above the feet.
  task automatic find_hit(output logic found, output logic [6:0] idx, output logic signed [10:0] y);
    int x, feet, px, py;
    found = 1'b0; idx = '0; y = '0;
    x = int'(dx);
    feet = int'(dy) + 80;
    for (int i = 0; i < NP; i++) begin
      px = int'($signed(plats[i][1]));
      py = int'($signed(plats[i][0]));
      if (!found && act[i] && fall && (x + 79 >= px) && (x <= px + 99) && (feet >= py) && (feet <= py + 11)) begin
        found = 1'b1;
        idx = 7'(i);
        y = 11'(py);
      end
    end
  endtask

  function automatic logic [FW-1:0] no_tick();
    return FW'($urandom_range(0, 1 << 20));
  endfunction

  task automatic launch(output int m);
    logic raw, rep;
    logic [6:0] ridx;
    logic signed [10:0] ry;
    exp_t e;
    @(negedge clk);
    find_hit(raw, ridx, ry);
`ifdef PLATFORM_COLLIDER_HOLDOFF_EN
    if (m_hold > 0) begin rep = 1'b0; m_hold--; end
    else begin rep = raw; if (raw) m_hold = 15; end
`else
    rep = raw;
`endif
    if (raw) begin m_idx = ridx; m_y = ry; end
    m_mc = rep;
    m = cyc;
    e.mc = m_mc; e.idx = m_idx; e.y = m_y; e.cyc = m + 95;
    q.push_back(e);
    fps = '1;
    @(negedge clk);
    fps = no_tick();
    // Scramble the doodle inputs: the scan must use its snapshot.
    dx = 11'($urandom); dy = 10'($urandom); fall = 1'($urandom);
  endtask

  task automatic run_scan(input bit extra_ticks);
    int m;
    int k;
    launch(m);
    for (k = 0; k < 200 && q.size() != 0; k++) begin
      @(negedge clk);
      if (extra_ticks && (cyc == m + 50 || cyc == m + 94)) fps = '1;
      else fps = no_tick();
    end
    if (q.size() != 0) begin
      check("scan_timeout", q.size(), 0);
      q.delete();
    end
  endtask

  task automatic base_setup();
    for (int i = 0; i < NP; i++) begin
      plats[i][1] = 11'($urandom_range(0, 600));
      plats[i][0] = 11'($urandom_range(0, 500));
    end
    act = '0;
    plats[5][1] = 11'd342;
    plats[5][0] = 11'd400;
    act[5] = 1'b1;
  endtask

  // Monitor
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        if (busy) busy_cnt++;
        else if (busy_cnt > 0) begin
          check("busy_len", busy_cnt, NP);
          busy_cnt = 0;
        end
        if (done) begin
          if (q.size() == 0) check("unexpected_scan_done", 1, 0);
          else begin
            e = q.pop_front();
            check("move_collision", mc, e.mc);
            check("hit_index", hidx, e.idx);
            check("hit_y", hy, e.y);
            check("done_cycle", cyc, e.cyc);
            cur_mc = e.mc; cur_idx = e.idx; cur_y = e.y;
          end
        end else begin
          check("hold", {mc, hidx, hy}, {cur_mc, cur_idx, cur_y});
        end
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  typedef struct { int x; int y; logic f; logic a; } dir_t;
  dir_t dirs[9] = '{
    '{360, 320, 1'b1, 1'b1}, '{360, 331, 1'b1, 1'b1}, '{360, 332, 1'b1, 1'b1},
    '{262, 320, 1'b1, 1'b1}, '{263, 320, 1'b1, 1'b1}, '{441, 320, 1'b1, 1'b1},
    '{442, 320, 1'b1, 1'b1}, '{360, 320, 1'b0, 1'b1}, '{360, 320, 1'b1, 1'b0}
  };

  initial begin
    int m, j, px, py;
    repeat (3) @(negedge clk);
    check("rst_mc", mc, 0);
    check("rst_idx", hidx, 0);
    check("rst_y", hy, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    rst = 1'b1;
    repeat (3) @(negedge clk);

    // Directed landing, window and qualifier cases
    base_setup();
    foreach (dirs[i]) begin
      dx = 11'(dirs[i].x); dy = 10'(dirs[i].y); fall = dirs[i].f; act[5] = dirs[i].a;
      run_scan(1'b0);
    end
    act = '0;
    plats[3][1] = 11'd342; plats[3][0] = 11'd400; act[3] = 1'b1;
    plats[7][1] = 11'd300; plats[7][0] = 11'd395; act[7] = 1'b1;
    dx = 11'd360; dy = 10'd320; fall = 1'b1;
    run_scan(1'b1);

    // Constant landing geometry across 17 scans
    base_setup();
    for (int s = 0; s < 17; s++) begin
      dx = 11'd360; dy = 10'd320; fall = 1'b1;
      run_scan(1'b0);
    end

    // Reset mid-scan
    dx = 11'd360; dy = 10'd320; fall = 1'b1;
    launch(m);
    while (cyc < m + 40) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("arst_mc", mc, 0);
    check("arst_idx", hidx, 0);
    check("arst_y", hy, 0);
    check("arst_busy", busy, 0);
    check("arst_done", done, 0);
    q.delete();
    busy_cnt = 0;
    cur_mc = 0; cur_idx = '0; cur_y = '0;
    m_mc = 0; m_idx = '0; m_y = '0; m_hold = 0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (150) begin
      @(negedge clk);
      fps = no_tick();
    end

    // Randomized scans
    for (int s = 0; s < 40; s++) begin
      for (int i = 0; i < NP; i++) begin
        act[i] = ($urandom_range(0, 3) == 0);
        plats[i][1] = 11'($urandom_range(0, 600));
        plats[i][0] = 11'(int'($urandom_range(0, 540)) - 40);
      end
      if ($urandom_range(0, 1) == 1) begin
        j = $urandom_range(0, NP - 1);
        px = $urandom_range(80, 560);
        py = $urandom_range(90, 480);
        plats[j][1] = 11'(px); plats[j][0] = 11'(py); act[j] = 1'b1;
        dx = 11'(px - 80 + int'($urandom_range(0, 180)));
        dy = 10'(py - 81 + int'($urandom_range(0, 13)));
      end else begin
        dx = 11'($urandom_range(0, 700));
        dy = 10'($urandom_range(0, 479));
      end
      fall = ($urandom_range(0, 3) != 0);
      run_scan(1'($urandom));
    end

    repeat (5) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
